gb_apu_mixer: RTL
=================

# gb_apu_mixer

Downstream stage of the four APU channel generators (two pulse channels, wave, noise). Converts each channel's 4-bit digital level through a per-channel DAC model and routes it to the left/right buses per NR51 panning. Sums and scales each bus by the NR50 master volume, then decimates to a fixed audio sample rate. Samples are delivered through a 2-entry valid/ready output FIFO, with a saturating count of dropped samples.

## Interface
Parameters:
- SAMPLE_DIV, default 95: clk cycles per output sample (4194304 Hz / 95 ≈ 44.15 kHz). Legal range is 2..65535.

Ports:
- clk  input  1  CPU clock (T-cycle rate). Single clock domain.
- reset  input  1  Synchronous, active-high reset.
- level  input  16  Channel levels. {ch4,ch3,ch2,ch1}, 4 bits each, unsigned 0..15.
- dac_en  input  4  Per-channel DAC power. Bit n corresponds to channel n+1.
- nr51  input  8  Panning. Bits 3:0 enable ch1..4 on the right bus; bits 7:4 enable ch1..4 on the left bus.
- nr50  input  8  Master volume. Bits 6:4 set left volume 0..7; bits 2:0 set right volume 0..7. Bits 7 and 3 (VIN) are ignored.
- apu_enable  input  1  NR52 bit 7.
- sample_left  output  16  Signed left sample at the FIFO head.
- sample_right  output  16  Signed right sample at the FIFO head.
- sample_valid  output  1  FIFO is non-empty.
- sample_ready  input  1  Consumer accepts the head sample when sample_valid is 1.
- overflow_count  output  8  Dropped samples, saturating at 255.

## Operation
The datapath is a 3-stage registered pipeline. It advances every clk and has no stall.

- S1, DAC and panning:
  - dac_n = 2*level_n − 15 (signed 5-bit, −15..+15) when dac_en[n]=1; otherwise 0.
  - Left term n = nr51[4+n] ? dac_n : 0. Right term n = nr51[n] ? dac_n : 0.
  - All eight terms are registered.
- S2, sum: each bus sums its four terms into a signed 7-bit register (range −60..+60). No saturation is needed.
- S3, scale:
  - Each bus sum is multiplied by (vol+1), giving signed 10-bit (range −480..+480).
  - The result is sign-extended and left-shifted 5 into the 16-bit output format (range −15360..+15360).
  - If apu_enable=0, S3 registers load 0.
- Decimator:
  - A 16-bit counter counts 0..SAMPLE_DIV−1 and wraps.
  - When the counter equals SAMPLE_DIV−1, a strobe captures the S3 left/right pair as a push to the FIFO.
- FIFO: 2 entries, storing left and right together.
  - Pop occurs when sample_valid & sample_ready.
  - A push while full with no pop in the same cycle is dropped and overflow_count increments, saturating at 255.
  - Push and pop in the same cycle while full: both happen and no drop.
  - Push and pop in the same cycle while holding one entry: occupancy stays 1 and the new sample becomes the head.
  - Order is strictly FIFO.
- The head sample and sample_valid must stay stable while sample_valid=1 and sample_ready=0.

## Timing
- Reset values:
  - All pipeline registers, FIFO storage and pointers, decimation counter, and overflow_count are 0.
  - sample_left, sample_right, and sample_valid are 0.
- Pipeline latency: an input change at cycle t is visible in the S3 registers at t+3.
- Strobe: the first strobe after reset is SAMPLE_DIV−1 cycles after reset deasserts, then every SAMPLE_DIV cycles.
- Push to output: a sample pushed into an empty FIFO at edge e shows sample_valid=1 after edge e.
- Pop to next head: a pop at edge e presents the next entry, or sample_valid=0, after edge e.
- sample_ready is sampled only at clk edges. No combinational path runs from sample_ready to any output.
- Reset mid-stream flushes the FIFO and restarts decimation; no partial sample survives.
- Changes to nr50, nr51, dac_en, and apu_enable take effect through the pipeline with the same 3-cycle latency. There is no glitch filtering.

## Test plan
- **Reset:** assert reset for 2 cycles with arbitrary inputs. Required: all outputs 0 and sample_valid=0; with sample_ready=1 and no strobe, sample_valid stays 0 for SAMPLE_DIV−2 cycles.
- **Single channel right:**
  - Stimulus: level ch1=15, dac_en=0001, nr51=0x01, nr50=0x07, apu_enable=1, sample_ready=1.
  - Required: each sample has right=3840 (15·8·32) and left=0.
- **All DACs at zero level:**
  - Stimulus: level=0, dac_en=1111, nr51=0xFF, nr50=0x00.
  - Required: left = right = −1920 (−60·1·32).
- **DAC off and apu_enable:**
  - Stimulus: ch2 level=15, dac_en=0000, nr51=0xFF.
  - Required: both outputs 0. With DACs on and apu_enable=0, both outputs are also 0.
- **Backpressure:**
  - Stimulus: sample_ready=0 across 3 strobes.
  - Required: sample_valid=1 with the first sample held stable; overflow_count=1 after the third strobe.
  - Then hold sample_ready=1 for 2 cycles. Required: the first two samples appear in order and sample_valid drops.
- **Full FIFO with simultaneous push and pop:**
  - Stimulus: FIFO full, sample_ready asserted exactly on the strobe cycle.
  - Required: no drop (overflow_count unchanged), occupancy stays 2, and the newest sample is at the tail.

Source files
------------

// File: rtl/gb_apu_mixer_if.sv
// Output sample handshake of the APU mixer: one stereo sample per transfer,
// qualified by valid/ready.
interface gb_apu_mixer_if;
    logic signed [15:0] sample_left;
    logic signed [15:0] sample_right;
    logic               sample_valid;
    logic               sample_ready;

    modport master (
        output sample_left,
        output sample_right,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_left,
        input  sample_right,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/gb_apu_mixer.sv
// Game Boy APU mixer: per-channel DAC, NR51 panning, NR50 volume, decimation
// to a fixed sample rate and a 2-entry stereo output FIFO with drop counting.
module gb_apu_mixer #(
    parameter int SAMPLE_DIV = 95
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [15:0]    level,
    input  logic [3:0]     dac_en,
    input  logic [7:0]     nr51,
    input  logic [7:0]     nr50,
    input  logic           apu_enable,
    gb_apu_mixer_if.master smp,
    output logic [7:0]     overflow_count
);
    localparam logic [15:0] CNT_LAST = 16'(SAMPLE_DIV - 1);

    logic signed [4:0]  term_l_d [4];
    logic signed [4:0]  term_r_d [4];
    logic signed [4:0]  term_l_q [4];
    logic signed [4:0]  term_r_q [4];
    logic [2:0]         s1_vol_l_q, s1_vol_r_q;
    logic               s1_en_q;

    logic signed [6:0]  sum_l_d, sum_r_d;
    logic signed [6:0]  sum_l_q, sum_r_q;
    logic [2:0]         s2_vol_l_q, s2_vol_r_q;
    logic               s2_en_q;

    logic signed [4:0]  gain_l, gain_r;
    logic signed [9:0]  scaled_l, scaled_r;
    logic signed [15:0] out_l_d, out_r_d;
    logic signed [15:0] out_l_q, out_r_q;

    logic [15:0]        cnt_d, cnt_q;
    logic               strobe;

    logic signed [15:0] mem_l_q [2];
    logic signed [15:0] mem_r_q [2];
    logic               rd_ptr_d, rd_ptr_q;
    logic               wr_ptr_d, wr_ptr_q;
    logic [1:0]         count_d, count_q;
    logic [7:0]         ovf_d, ovf_q;
    logic               pop, push_ok, drop;

    // VIN bits of NR50 have no effect on the mix.
    logic unused_vin;
    assign unused_vin = nr50[7] ^ nr50[3];

    // 2*level-15 fits 5-bit two's complement, so modular arithmetic is exact.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_chan
            logic [4:0] dac_val;
            assign dac_val      = {level[4*gi +: 4], 1'b0} - 5'd15;
            assign term_l_d[gi] = (dac_en[gi] && nr51[4+gi]) ? dac_val : 5'd0;
            assign term_r_d[gi] = (dac_en[gi] && nr51[gi])   ? dac_val : 5'd0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                term_l_q[i] <= '0;
                term_r_q[i] <= '0;
            end
            s1_vol_l_q <= '0;
            s1_vol_r_q <= '0;
            s1_en_q    <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                term_l_q[i] <= term_l_d[i];
                term_r_q[i] <= term_r_d[i];
            end
            s1_vol_l_q <= nr50[6:4];
            s1_vol_r_q <= nr50[2:0];
            s1_en_q    <= apu_enable;
        end
    end

    always_comb begin
        sum_l_d = '0;
        sum_r_d = '0;
        for (int i = 0; i < 4; i++) begin
            sum_l_d = sum_l_d + 7'(term_l_q[i]);
            sum_r_d = sum_r_d + 7'(term_r_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_l_q    <= '0;
            sum_r_q    <= '0;
            s2_vol_l_q <= '0;
            s2_vol_r_q <= '0;
            s2_en_q    <= 1'b0;
        end else begin
            sum_l_q    <= sum_l_d;
            sum_r_q    <= sum_r_d;
            s2_vol_l_q <= s1_vol_l_q;
            s2_vol_r_q <= s1_vol_r_q;
            s2_en_q    <= s1_en_q;
        end
    end

    assign gain_l   = $signed({2'b00, s2_vol_l_q}) + 5'sd1;
    assign gain_r   = $signed({2'b00, s2_vol_r_q}) + 5'sd1;
    assign scaled_l = 10'(sum_l_q) * 10'(gain_l);
    assign scaled_r = 10'(sum_r_q) * 10'(gain_r);
    assign out_l_d  = s2_en_q ? {scaled_l[9], scaled_l, 5'b00000} : 16'sd0;
    assign out_r_d  = s2_en_q ? {scaled_r[9], scaled_r, 5'b00000} : 16'sd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_l_q <= '0;
            out_r_q <= '0;
        end else begin
            out_l_q <= out_l_d;
            out_r_q <= out_r_d;
        end
    end

    assign strobe = (cnt_q == CNT_LAST);
    assign cnt_d  = strobe ? 16'd0 : cnt_q + 16'd1;

    // A push into a full FIFO survives only if the head leaves on the same edge.
    assign pop     = (count_q != 2'd0) && smp.sample_ready;
    assign push_ok = strobe && ((count_q != 2'd2) || pop);
    assign drop    = strobe && (count_q == 2'd2) && !pop;

    assign rd_ptr_d = rd_ptr_q ^ pop;
    assign wr_ptr_d = wr_ptr_q ^ push_ok;
    assign ovf_d    = (drop && (ovf_q != 8'hFF)) ? ovf_q + 8'd1 : ovf_q;

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + 2'd1;
        end else if (!push_ok && pop) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= '0;
            ovf_q    <= '0;
            for (int i = 0; i < 2; i++) begin
                mem_l_q[i] <= '0;
                mem_r_q[i] <= '0;
            end
        end else begin
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            if (push_ok) begin
                mem_l_q[wr_ptr_q] <= out_l_q;
                mem_r_q[wr_ptr_q] <= out_r_q;
            end
        end
    end

    assign smp.sample_left  = mem_l_q[rd_ptr_q];
    assign smp.sample_right = mem_r_q[rd_ptr_q];
    assign smp.sample_valid = (count_q != 2'd0);
    assign overflow_count   = ovf_q;
endmodule
